// File: rtl/tff_bank_sequencer_pkg.sv
// Shared command encodings and FSM state type for the TFF bank sequencer.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tff_bank_sequencer_if.sv
// Valid/ready command channel feeding the TFF bank sequencer.
interface tff_bank_sequencer_if #(
    parameter int WIDTH = tff_seq_pkg::DEFAULT_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/tff_bank_sequencer_cell.sv
// Single behavioural T flip-flop: q inverts on each rising edge where t is high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Command FSM driving a bank of WIDTH T flip-flops as a loadable up/down counter.
// Optional abort input is enabled by defining TFF_SEQ_ABORT_EN.
module tff_bank_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    tff_bank_sequencer_if.slave cmd,
`ifdef TFF_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] stepCnt_q, stepCnt_d;
    logic             ready_q, busy_q, done_q, wrap_q;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] upT, downT, lowMask;
    logic             wrapHit;
    logic             abortReq;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (toggle[i]),
            .q   (count[i])
        );
    end

`ifdef TFF_SEQ_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    // Cell i flips when all lower cells are ones (up) or all zeros (down).
    always_comb begin
        upT     = '0;
        downT   = '0;
        lowMask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lowMask  = (WIDTH'(1) << i) - WIDTH'(1);
            upT[i]   = ((count & lowMask) == lowMask);
            downT[i] = ((count & lowMask) == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_d     = arg_q;
        stepCnt_d = stepCnt_q;
        toggle    = '0;
        wrapHit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    op_d  = op_e'(cmd.cmd_op);
                    arg_d = cmd.cmd_arg;
                    if (cmd.cmd_op == OP_CLEAR || cmd.cmd_op == OP_LOAD) begin
                        state_d = S_APPLY;
                    end else if (cmd.cmd_arg != '0) begin
                        state_d   = S_RUN;
                        stepCnt_d = cmd.cmd_arg;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_APPLY: begin
                toggle  = (op_q == OP_CLEAR) ? count : (count ^ arg_q);
                state_d = S_DONE;
            end
            // Once all steps are taken RUN holds one settle cycle so done trails the last count.
            S_RUN: begin
                if (abortReq || stepCnt_q == '0) begin
                    stepCnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    stepCnt_d = stepCnt_q - WIDTH'(1);
                    if (op_q == OP_UP) begin
                        toggle  = upT;
                        wrapHit = &count;
                    end else begin
                        toggle  = downT;
                        wrapHit = ~|count;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_CLEAR;
            arg_q     <= '0;
            stepCnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            stepCnt_q <= stepCnt_d;
            ready_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d == S_APPLY) || (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            wrap_q    <= wrapHit;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign wrap          = wrap_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Scoreboard bench for tff_bank_sequencer; abort scenario runs when TFF_SEQ_ABORT_EN is defined.
module tb_tff_bank_sequencer;
    import tff_seq_pkg::*;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    typedef struct {
        string      name;
        logic [7:0] finalCount;
        int         wraps;
        logic [7:0] wrapValue;
        int         doneCnt;
    } sbItem;

    logic        clk;
    logic        rst;
    logic        abort;
    logic [7:0]  count;
    logic        busy, done, wrap;
    int          compared;
    int          mismatched;
    int          cycleCnt;
    int          modelCount;
    sbItem       expQ[$];

    tff_bank_sequencer_if #(.WIDTH(W)) cmd_if ();

    tff_bank_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd_if.slave),
`ifdef TFF_SEQ_ABORT_EN
        .abort (abort),
`endif
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference: counts are plain modular arithmetic; latency follows the command timing table.
    function automatic sbItem modelCmd(input logic [1:0] op, input int arg, input int acc,
                                       input int abortAfter);
        sbItem it;
        int    steps, total, lat;
        it.wraps     = 0;
        it.wrapValue = 8'h00;
        case (op)
            2'b00: begin it.name = "CLEAR"; total = 0;   lat = 2; end
            2'b01: begin it.name = "LOAD";  total = arg; lat = 2; end
            default: begin
                steps = (abortAfter >= 0 && abortAfter < arg) ? abortAfter : arg;
                lat   = (arg == 0) ? 1 : steps + 2;
                if (op == 2'b10) begin
                    it.name  = "UP";
                    total    = modelCount + steps;
                    it.wraps = total / MOD;
                end else begin
                    it.name      = "DOWN";
                    total        = modelCount - steps;
                    it.wrapValue = 8'(MOD - 1);
                    it.wraps     = (total < 0) ? 1 : 0;
                end
            end
        endcase
        modelCount    = ((total % MOD) + MOD) % MOD;
        it.finalCount = 8'(modelCount);
        it.doneCnt    = acc + lat - 1;
        return it;
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] arg, input bit hold,
                                 input int abortAfter, output int acc);
        int guard;
        guard = 0;
        acc   = -1;
        @(negedge clk);
        while (!cmd_if.cmd_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_if.cmd_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        @(posedge clk);
        #1;
        acc = cycleCnt;
        expQ.push_back(modelCmd(op, int'(arg), acc, abortAfter));
        if (!hold) cmd_if.cmd_valid = 1'b0;
    endtask

    // Monitor: checks wrap alignment and pops one expectation per done pulse.
    initial begin
        int wrapsSeen;
        sbItem it;
        wrapsSeen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wrapsSeen = 0;
            end else begin
                if (wrap) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_wrap", 1, 0);
                    end else begin
                        checkOutput({expQ[0].name, "_wrap_value"}, int'(count), int'(expQ[0].wrapValue));
                        wrapsSeen++;
                    end
                end
                if (done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        it = expQ.pop_front();
                        checkOutput({it.name, "_count"}, int'(count), int'(it.finalCount));
                        checkOutput({it.name, "_wraps"}, wrapsSeen, it.wraps);
                        checkOutput({it.name, "_done_cycle"}, cycleCnt, it.doneCnt);
                        checkOutput({it.name, "_busy_at_done"}, int'(busy), 0);
                    end
                    wrapsSeen = 0;
                end
            end
        end
    end

    initial begin
        int acc, guard;
        logic [1:0] op;
        logic [7:0] arg;
        compared         = 0;
        mismatched       = 0;
        cycleCnt         = 0;
        modelCount       = 0;
        rst              = 1'b1;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_arg   = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_wrap", int'(wrap), 0);

        applyStimulus(2'b01, 8'h3C, 1'b0, -1, acc);
        applyStimulus(2'b01, 8'hA5, 1'b0, -1, acc);
        applyStimulus(2'b01, 8'hFD, 1'b0, -1, acc);
        applyStimulus(2'b10, 8'd5,  1'b0, -1, acc);
        applyStimulus(2'b01, 8'h01, 1'b0, -1, acc);
        applyStimulus(2'b11, 8'd3,  1'b0, -1, acc);
        applyStimulus(2'b00, 8'h77, 1'b0, -1, acc);
        applyStimulus(2'b01, 8'h42, 1'b0, -1, acc);

        // Valid stays high through the command; only one accept may happen per ready window.
        applyStimulus(2'b10, 8'd0, 1'b1, -1, acc);
        applyStimulus(2'b10, 8'd4, 1'b1, -1, acc);
        @(negedge clk);
        checkOutput("hold_busy", int'(busy), 1);
        checkOutput("hold_ready", int'(cmd_if.cmd_ready), 0);
        applyStimulus(2'b11, 8'd2, 1'b0, -1, acc);

        // Async reset in the middle of a run discards the command.
        applyStimulus(2'b10, 8'd10, 1'b0, -1, acc);
        repeat (4) @(negedge clk);
        expQ.delete();
        rst = 1'b1;
        #1;
        modelCount = 0;
        checkOutput("midrun_reset_count", int'(count), 0);
        checkOutput("midrun_reset_busy", int'(busy), 0);
        checkOutput("midrun_reset_done", int'(done), 0);
        checkOutput("midrun_reset_ready", int'(cmd_if.cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("post_reset_count", int'(count), 0);

`ifdef TFF_SEQ_ABORT_EN
        applyStimulus(2'b10, 8'd20, 1'b0, 6, acc);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        for (int n = 0; n < 30; n++) begin
            op  = 2'($urandom_range(0, 3));
            arg = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 12));
            applyStimulus(op, arg, 1'b0, -1, acc);
        end

        guard = 0;
        while (expQ.size() != 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
